// File: rtl/hb_pkg.sv
// Shared types and constants for the heartbeat LED controller: FSM states,
// LED modes and the bit layout of the HPS control word.
package hb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } hb_state_e;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_BLINK   = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_SOLID   = 2'b11;

  localparam int unsigned KICK_BIT   = 0;
  localparam int unsigned ENABLE_BIT = 1;
  localparam int unsigned MODE_LSB   = 2;
  localparam int unsigned MODE_MSB   = 3;
  localparam int unsigned BRIGHT_LSB = 8;
  localparam int unsigned BRIGHT_MSB = 15;
  localparam int unsigned HALF_LSB   = 16;
  localparam int unsigned HALF_MSB   = 31;

  // Full scale is forced on so 8'hFF means a solid, flicker-free LED.
  function automatic logic pwm_out(input logic [7:0] cnt, input logic [7:0] duty);
    return (cnt < duty) || (duty == 8'hFF);
  endfunction

endpackage

// File: rtl/hb_tick_gen.sv
// Free-running prescaler producing a one-clock tick pulse every DIV clocks.
module hb_tick_gen #(
  parameter int unsigned DIV = 50_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/heartbeat_led_ctrl.sv
// Board LED driver for the HPS heartbeat PIO: blink/breathe/solid patterns with
// 8-bit PWM, plus a kick watchdog that switches to a fault flash on timeout.
module heartbeat_led_ctrl
  import hb_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_HZ    = 1_000,
  parameter int unsigned WDT_TICKS  = 2000,
  parameter int unsigned FAULT_HALF = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ctrl_word,
  output logic        led,
  output logic        hb_alive,
  output logic        hb_fault
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned WdtW  = $clog2(WDT_TICKS + 1);
  localparam int unsigned FcntW = (FAULT_HALF > 1) ? $clog2(FAULT_HALF) : 1;

  logic [31:0]      ctrl_q;
  logic             kick_prev_q;
  hb_state_e        state_q, state_d;
  logic [WdtW-1:0]  wdt_q, wdt_d;
  logic [15:0]      pcnt_q, pcnt_d;
  logic             phase_q, phase_d;
  logic [7:0]       level_q, level_d;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  logic             fault_on_q, fault_on_d;
  logic [7:0]       pwm_cnt_q;
  logic             led_q, led_d;
  logic             tick;

  logic        kick_edge, enable;
  logic [1:0]  mode;
  logic [7:0]  bright;
  logic [15:0] half, half_m1;
  logic        unused_rsvd;

  hb_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  assign kick_edge   = ctrl_q[KICK_BIT] ^ kick_prev_q;
  assign enable      = ctrl_q[ENABLE_BIT];
  assign mode        = ctrl_q[MODE_MSB:MODE_LSB];
  assign bright      = ctrl_q[BRIGHT_MSB:BRIGHT_LSB];
  assign half        = (ctrl_q[HALF_MSB:HALF_LSB] == 16'd0) ? 16'd1 : ctrl_q[HALF_MSB:HALF_LSB];
  assign half_m1     = half - 16'd1;
  assign unused_rsvd = ^ctrl_q[7:4];

  always_comb begin
    state_d    = state_q;
    wdt_d      = wdt_q;
    pcnt_d     = pcnt_q;
    phase_d    = phase_q;
    level_d    = level_q;
    fcnt_d     = fcnt_q;
    fault_on_d = fault_on_q;
    led_d      = 1'b0;

    // Disable overrides both kick and timeout.
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          wdt_d   = '0;
        end
        RUN: begin
          if (kick_edge) begin
            wdt_d = '0;
          end else if (tick) begin
            wdt_d = wdt_q + 1'b1;
            if (wdt_q == WdtW'(WDT_TICKS - 1)) state_d = FAULT;
          end
        end
        FAULT: begin
          if (kick_edge) begin
            state_d = RUN;
            wdt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_q == RUN && tick) begin
      // >= so a shrunk half period wraps on the very next tick.
      if (pcnt_q >= half_m1) begin
        pcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        pcnt_d = pcnt_q + 16'd1;
      end
      if (!phase_q) begin
        level_d = (level_q >= bright) ? bright : level_q + 8'd1;
      end else if (level_q > bright) begin
        level_d = bright;
      end else if (level_q != 8'd0) begin
        level_d = level_q - 8'd1;
      end
    end
    if (state_d == RUN && state_q != RUN) begin
      pcnt_d  = '0;
      phase_d = 1'b0;
      level_d = '0;
    end

    if (state_q == FAULT && tick) begin
      if (fcnt_q >= FcntW'(FAULT_HALF - 1)) begin
        fcnt_d     = '0;
        fault_on_d = ~fault_on_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    if (state_d == FAULT && state_q != FAULT) begin
      fcnt_d     = '0;
      fault_on_d = 1'b1;
    end

    case (state_q)
      FAULT: led_d = fault_on_q;
      RUN: begin
        case (mode)
          MODE_BLINK:   led_d = !phase_q && pwm_out(pwm_cnt_q, bright);
          MODE_BREATHE: led_d = pwm_out(pwm_cnt_q, level_q);
          MODE_SOLID:   led_d = pwm_out(pwm_cnt_q, bright);
          default:      led_d = 1'b0;
        endcase
      end
      default: led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= '0;
      kick_prev_q <= 1'b0;
      state_q     <= IDLE;
      wdt_q       <= '0;
      pcnt_q      <= '0;
      phase_q     <= 1'b0;
      level_q     <= '0;
      fcnt_q      <= '0;
      fault_on_q  <= 1'b0;
      pwm_cnt_q   <= '0;
      led_q       <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_word;
      kick_prev_q <= ctrl_q[KICK_BIT];
      state_q     <= state_d;
      wdt_q       <= wdt_d;
      pcnt_q      <= pcnt_d;
      phase_q     <= phase_d;
      level_q     <= level_d;
      fcnt_q      <= fcnt_d;
      fault_on_q  <= fault_on_d;
      pwm_cnt_q   <= pwm_cnt_q + 8'd1;
      led_q       <= led_d;
    end
  end

  assign led      = led_q;
  assign hb_alive = (state_q == RUN);
  assign hb_fault = (state_q == FAULT);

endmodule
